// File: rtl/stage_ibuf.sv
`default_nettype none
// ============================================================================
// Module   : stage_ibuf
// Brief    : Two-entry skid input buffer for a pipeline stage boundary.
//            Accepts an upstream valid/ready payload and presents it to the
//            consuming stage from the main register. A second (skid) entry
//            absorbs one cycle of back-pressure, so s_ready is a pure
//            function of registered state with no path from m_ready.
//            Optional flush port enabled by defining STAGE_IBUF_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stage_ibuf #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       count
`ifdef STAGE_IBUF_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    // Next-state and data-path selection; data registers only change on capture.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (s_valid) begin
                    main_d  = s_data;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (s_valid && m_ready) begin
                    // Back-to-back streaming: head is consumed and replaced.
                    main_d = s_data;
                end else if (s_valid) begin
                    skid_d  = s_data;
                    state_d = S_FULL;
                end else if (m_ready) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // s_ready is low here, so s_valid is ignored.
                if (m_ready) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
`ifdef STAGE_IBUF_FLUSH_EN
        // Flush overrides any handshake; stale data is left in place.
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
`endif
    end

    // State and storage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Occupancy and handshake outputs decoded from registered state only.
    always_comb begin
        count   = 2'd0;
        m_valid = 1'b0;
        s_ready = 1'b1;
        case (state_q)
            S_ONE: begin
                count   = 2'd1;
                m_valid = 1'b1;
            end
            S_FULL: begin
                count   = 2'd2;
                m_valid = 1'b1;
                s_ready = 1'b0;
            end
            default: begin
                count   = 2'd0;
            end
        endcase
    end

    assign m_data = main_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_ibuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_ibuf
// Brief    : Self-checking bench for stage_ibuf (WIDTH = 8). A reference
//            queue model tracks accepted payloads; every cycle the DUT's
//            handshake outputs, occupancy and head payload are compared
//            against it, alongside directed checks for each scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_ibuf;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic [1:0]   count;
    logic         flush;

    int n_tests = 0;
    int n_fail  = 0;

    stage_ibuf #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
`ifdef STAGE_IBUF_FLUSH_EN
        ,
        .flush   (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: scoreboard queue of accepted payloads.
    logic [W-1:0] sb_q[$];
    int           mdl_cnt    = 0;
    bit           known_zero = 1'b1;
    bit           started    = 1'b0;

    always @(posedge clk) begin
        bit in_x;
        bit out_x;
        started = 1'b1;
        if (!rst_n) begin
            sb_q.delete();
            mdl_cnt    = 0;
            known_zero = 1'b1;
        end else if (flush) begin
            sb_q.delete();
            mdl_cnt = 0;
        end else begin
            in_x  = s_valid && (mdl_cnt != 2);
            out_x = m_ready && (mdl_cnt != 0);
            if (out_x) void'(sb_q.pop_front());
            if (in_x) begin
                sb_q.push_back(s_data);
                known_zero = 1'b0;
            end
            mdl_cnt = mdl_cnt + int'(in_x) - int'(out_x);
        end
    end

    // Per-cycle comparison of DUT outputs with the model, away from the edge.
    always @(negedge clk) begin
        if (started) begin
            chk("mon_count",   {30'd0, count},   mdl_cnt);
            chk("mon_m_valid", {31'd0, m_valid}, {31'd0, mdl_cnt != 0});
            chk("mon_s_ready", {31'd0, s_ready}, {31'd0, mdl_cnt != 2});
            if (mdl_cnt != 0)
                chk("mon_m_data", {24'd0, m_data}, {24'd0, sb_q[0]});
            else if (known_zero)
                chk("mon_m_data_zero", {24'd0, m_data}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        flush   = 1'b0;

        // Reset then idle
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_count",   {30'd0, count},   32'd0);
        chk("rst_m_data",  {24'd0, m_data},  32'd0);

        // Streaming with m_ready held high
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 8'h11; step();
        chk("str_data0", {24'd0, m_data}, 32'h11);
        chk("str_cnt0",  {30'd0, count},  32'd1);
        s_data = 8'h22; step();
        chk("str_data1", {24'd0, m_data}, 32'h22);
        chk("str_rdy1",  {31'd0, s_ready}, 32'd1);
        s_data = 8'h33; step();
        chk("str_data2", {24'd0, m_data}, 32'h33);
        chk("str_cnt2",  {30'd0, count},  32'd1);
        s_valid = 1'b0; step();
        chk("str_drain", {30'd0, count}, 32'd0);

        // Stall into FULL, then hold s_valid with 0xB0 while full
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'hA1; step();
        chk("stl_cnt1", {30'd0, count}, 32'd1);
        s_data = 8'hA2; step();
        chk("stl_cnt2",  {30'd0, count},   32'd2);
        chk("stl_rdy",   {31'd0, s_ready}, 32'd0);
        chk("stl_data",  {24'd0, m_data},  32'hA1);
        s_data = 8'hB0; step();
        chk("stl_hold_cnt",  {30'd0, count},  32'd2);
        chk("stl_hold_data", {24'd0, m_data}, 32'hA1);
        m_ready = 1'b1; step();
        chk("pop1_data", {24'd0, m_data},  32'hA2);
        chk("pop1_cnt",  {30'd0, count},   32'd1);
        chk("pop1_rdy",  {31'd0, s_ready}, 32'd1);
        step();
        chk("pop2_data", {24'd0, m_data}, 32'hB0);
        chk("pop2_cnt",  {30'd0, count},  32'd1);
        s_valid = 1'b0; step();
        chk("pop3_cnt",  {30'd0, count},  32'd0);

`ifdef STAGE_IBUF_FLUSH_EN
        // Flush from FULL with both handshakes requested
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'hC1; step();
        s_data = 8'hC2; step();
        chk("fl_pre_cnt", {30'd0, count}, 32'd2);
        flush = 1'b1; m_ready = 1'b1; s_data = 8'hC3; step();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        chk("fl_cnt",     {30'd0, count},   32'd0);
        chk("fl_m_valid", {31'd0, m_valid}, 32'd0);
        chk("fl_s_ready", {31'd0, s_ready}, 32'd1);
        step();
        chk("fl_cnt_after", {30'd0, count}, 32'd0);
`endif

        // Mid-operation reset while FULL with s_valid asserted
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 8'hD1; step();
        s_data = 8'hD2; step();
        chk("mr_pre_cnt", {30'd0, count}, 32'd2);
        rst_n = 1'b0; s_data = 8'hD3; step();
        rst_n = 1'b1; s_valid = 1'b0;
        chk("mr_cnt",     {30'd0, count},   32'd0);
        chk("mr_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mr_m_data",  {24'd0, m_data},  32'd0);
        step();
        chk("mr_cnt_after", {30'd0, count}, 32'd0);

        // Pseudo-random traffic checked by the per-cycle monitor
        for (int i = 0; i < 60; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = W'($urandom);
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) step();
        chk("final_cnt", {30'd0, count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
